// File: rtl/rv_pkg.sv
// rv_pkg: shared ALU/M-extension encodings for the EX stage.
package rv_pkg;
  localparam int MD_ITER = 32;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_ctrl_e;
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
endpackage

// File: rtl/rv_alu.sv
// rv_alu: single-cycle integer ALU.
module rv_alu import rv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  alu_ctrl_e         ctrl,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   res
);
  localparam int SH = $clog2(XLEN);
  logic [SH-1:0] shamt;
  assign shamt = b[SH-1:0];
  always_comb begin
    res = b;
    case (ctrl)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_SLL:  res = a << shamt;
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  res = a ^ b;
      ALU_SRL:  res = a >> shamt;
      ALU_SRA:  res = $signed(a) >>> shamt;
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      default:  ;
    endcase
  end
endmodule

// File: rtl/rv_muldiv_iter.sv
// rv_muldiv_iter: radix-2 shift-add multiplier / restoring divider on magnitudes.
module rv_muldiv_iter import rv_pkg::*; #(
  parameter int XLEN = MD_ITER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              start,
  input  md_op_e            op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result
);
  localparam int CW = $clog2(XLEN);
  logic            running, neg_q, neg_d, sa, sb, div_ok;
  logic [CW-1:0]   cnt;
  logic [2:0]      opv, op_q;
  logic [XLEN-1:0] hi, lo, m, abs_a, abs_b, hi_nx, lo_nx, q_c, r_c;
  logic [XLEN:0]   mul_sum, div_rs, div_diff;
  logic [2*XLEN-1:0] prod_c;
  assign opv = op;
  always_comb begin
    sa = a[XLEN-1] & (opv[2] ? !opv[0] : opv != MD_MULHU);
    sb = b[XLEN-1] & (opv[2] ? !opv[0] : !opv[1]);
    abs_a = sa ? -a : a;
    abs_b = sb ? -b : b;
    // a zero divisor keeps the all-ones quotient unsigned; remainder follows the dividend
    neg_d = (opv[2] & opv[1]) ? sa : (sa ^ sb) & (!opv[2] | (b != '0));
  end
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    div_rs   = {hi, lo[XLEN-1]};
    div_diff = div_rs - {1'b0, m};
    div_ok   = !div_diff[XLEN];
    hi_nx    = op_q[2] ? (div_ok ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0]) : mul_sum[XLEN:1];
    lo_nx    = op_q[2] ? {lo[XLEN-2:0], div_ok} : {mul_sum[0], lo[XLEN-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst || abort) running <= 1'b0;
    else if (start) running <= 1'b1;
    else if (done) running <= 1'b0;
    if (rst || abort || start) cnt <= '0;
    else if (running) cnt <= cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (start) begin
      op_q  <= opv;
      neg_q <= neg_d;
      hi    <= '0;
      lo    <= opv[2] ? abs_a : abs_b;
      m     <= opv[2] ? abs_b : abs_a;
    end else if (running) begin
      hi <= hi_nx;
      lo <= lo_nx;
    end
  end
  assign busy = running;
  assign done = running && cnt == CW'(XLEN-1);
  always_comb begin
    prod_c = neg_q ? -{hi, lo} : {hi, lo};
    q_c    = neg_q ? -lo : lo;
    r_c    = neg_q ? -hi : hi;
    result = !op_q[2] ? (op_q == MD_MUL ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN])
                      : (op_q[1] ? r_c : q_c);
  end
endmodule

// File: rtl/rv_stage_ex_md.sv
// rv_stage_ex_md: execute stage with operand forwarding, ALU and iterative M-extension unit.
module rv_stage_ex_md import rv_pkg::*; #(
  parameter int XLEN   = 32,
  parameter int N_FWD  = 2,
  parameter int SIDE_W = 8
) (
  input  logic                          i_ex_clk,
  input  logic                          i_ex_rst,
  input  logic                          i_ex_valid,
  input  logic                          i_ex_flush,
  input  logic [XLEN-1:0]               i_ex_pc,
  input  logic [XLEN-1:0]               i_ex_ext_imm,
  input  alu_ctrl_e                     i_ex_alu_ctrl,
  input  logic                          i_ex_alu_a_sel,
  input  logic                          i_ex_alu_b_sel,
  input  logic                          i_ex_md_en,
  input  md_op_e                        i_ex_md_op,
  input  logic [XLEN-1:0]               i_ex_rf_rdata [1:2],
  input  logic [$clog2(N_FWD+1)-1:0]    i_ex_rf_rdata_sel [1:2],
  input  logic [XLEN-1:0]               i_ex_fwd_data [1:N_FWD],
  input  logic [4:0]                    i_ex_rf_waddr,
  input  logic                          i_ex_rf_wen,
  input  logic                          i_ex_dmem_wen,
  input  logic [SIDE_W-1:0]             i_ex_side,
  output logic                          o_ex_stall,
  output logic [XLEN-1:0]               o_ex_if_alu_res,
  output logic [XLEN-1:0]               o_ex_if_pc_plus_4,
  output logic [XLEN-1:0]               o_ex_bu_rf_rdata_muxed [1:2],
  output logic                          o_ex_mem_valid,
  output logic                          o_ex_mem_rf_wen,
  output logic                          o_ex_mem_dmem_wen,
  output logic [XLEN-1:0]               o_ex_mem_res,
  output logic [XLEN-1:0]               o_ex_mem_pc_plus_4,
  output logic [XLEN-1:0]               o_ex_mem_ext_imm,
  output logic [XLEN-1:0]               o_ex_mem_dmem_wdata,
  output logic [4:0]                    o_ex_mem_rf_waddr,
  output logic [SIDE_W-1:0]             o_ex_mem_side
);
  localparam int SW = $clog2(N_FWD+1);
  md_state_e       state_q, state_d;
  logic            md_go, md_start, md_busy, md_done, is_done, adv;
  logic [XLEN-1:0] alu_a, alu_b, alu_res, md_res;
  always_comb begin
    for (int k = 1; k <= 2; k++) begin
      o_ex_bu_rf_rdata_muxed[k] = i_ex_rf_rdata[k];
      for (int j = 1; j <= N_FWD; j++)
        if (i_ex_rf_rdata_sel[k] == SW'(j)) o_ex_bu_rf_rdata_muxed[k] = i_ex_fwd_data[j];
    end
  end
  assign alu_a = i_ex_alu_a_sel ? i_ex_pc : o_ex_bu_rf_rdata_muxed[1];
  assign alu_b = i_ex_alu_b_sel ? o_ex_bu_rf_rdata_muxed[2] : i_ex_ext_imm;
  rv_alu #(.XLEN(XLEN)) u_alu (
    .ctrl (i_ex_alu_ctrl),
    .a    (alu_a),
    .b    (alu_b),
    .res  (alu_res)
  );
  assign o_ex_if_alu_res   = alu_res;
  assign o_ex_if_pc_plus_4 = i_ex_pc + XLEN'(4);
  assign md_go = i_ex_valid & i_ex_md_en & !i_ex_flush;
  always_ff @(posedge i_ex_clk) begin
    if (i_ex_rst) state_q <= MD_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = i_ex_flush ? MD_IDLE
            : state_q == MD_IDLE ? (md_go ? MD_BUSY : MD_IDLE)
            : state_q == MD_BUSY ? (md_done ? MD_DONE : md_busy ? MD_BUSY : MD_IDLE)
            : MD_IDLE;
  end
  always_comb begin
    md_start   = state_q == MD_IDLE && md_go;
    o_ex_stall = md_start || (state_q == MD_BUSY && !i_ex_flush);
    is_done    = state_q == MD_DONE && !i_ex_flush;
  end
  rv_muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk    (i_ex_clk),
    .rst    (i_ex_rst),
    .abort  (i_ex_flush),
    .start  (md_start),
    .op     (i_ex_md_op),
    .a      (o_ex_bu_rf_rdata_muxed[1]),
    .b      (o_ex_bu_rf_rdata_muxed[2]),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_res)
  );
  assign adv = i_ex_valid && !i_ex_flush && !o_ex_stall;
  always_ff @(posedge i_ex_clk) begin
    if (i_ex_rst) begin
      o_ex_mem_valid    <= 1'b0;
      o_ex_mem_rf_wen   <= 1'b0;
      o_ex_mem_dmem_wen <= 1'b0;
    end else begin
      o_ex_mem_valid    <= adv;
      o_ex_mem_rf_wen   <= adv && i_ex_rf_wen;
      o_ex_mem_dmem_wen <= adv && i_ex_dmem_wen;
    end
  end
  always_ff @(posedge i_ex_clk) begin
    o_ex_mem_res        <= is_done ? md_res : alu_res;
    o_ex_mem_pc_plus_4  <= o_ex_if_pc_plus_4;
    o_ex_mem_ext_imm    <= i_ex_ext_imm;
    o_ex_mem_dmem_wdata <= o_ex_bu_rf_rdata_muxed[2];
    o_ex_mem_rf_waddr   <= i_ex_rf_waddr;
    o_ex_mem_side       <= i_ex_side;
  end
endmodule

// File: doc/rv_stage_ex_md.md
RV_STAGE_EX_MD -- requirements
Module: rv_stage_ex_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter N_FWD, default 2, number of forwarding sources.
REQ-003 SHALL have parameter SIDE_W, default 8, opaque sideband width (func3, is_load, wdata_pre_sel, ...) carried ID->MEM unchanged.
REQ-004 Ports SHALL be as follows; one clock; reset is synchronous and active-high:
- i_ex_clk  in  1  clock; all state on rising edge.
- i_ex_rst  in  1  synchronous active-high reset.
- i_ex_valid  in  1  ID/EX holds a live instruction.
- i_ex_flush  in  1  kill current EX instruction.
- i_ex_pc, i_ex_ext_imm  in  XLEN  PC, extended immediate.
- i_ex_alu_ctrl  in  rv_pkg::alu_ctrl_e  ALU op.
- i_ex_alu_a_sel, i_ex_alu_b_sel  in  1  a: 1=PC, 0=rs1; b: 1=rs2, 0=imm.
- i_ex_md_en  in  1  instruction is M-extension.
- i_ex_md_op  in  rv_pkg::md_op_e  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- i_ex_rf_rdata[1:2]  in  XLEN  register-file operands.
- i_ex_rf_rdata_sel[1:2]  in  $clog2(N_FWD+1)  0=RF, k=forward source k.
- i_ex_fwd_data[1:N_FWD]  in  XLEN  forwarded values.
- i_ex_rf_waddr  in  5; i_ex_rf_wen, i_ex_dmem_wen  in  1; i_ex_side  in  SIDE_W.
- o_ex_stall  out  1  freeze IF/ID and ID/EX.
- o_ex_if_alu_res, o_ex_if_pc_plus_4  out  XLEN  combinational, to IF.
- o_ex_bu_rf_rdata_muxed[1:2]  out  XLEN  forwarded operands, to branch unit.
- o_ex_mem_valid, o_ex_mem_rf_wen, o_ex_mem_dmem_wen  out  1  EX/MEM control.
- o_ex_mem_res, o_ex_mem_pc_plus_4, o_ex_mem_ext_imm, o_ex_mem_dmem_wdata  out  XLEN.
- o_ex_mem_rf_waddr  out  5; o_ex_mem_side  out  SIDE_W.

Function
REQ-005 Operand k SHALL be i_ex_fwd_data[sel] for 1<=sel<=N_FWD, else i_ex_rf_rdata[k].
REQ-006 Non-MD instruction: ALU result and PC+4 registered into EX/MEM at next edge, latency 1, o_ex_stall=0.
REQ-007 FSM states IDLE, BUSY, DONE; reset/flush -> IDLE.
REQ-008 IDLE & i_ex_valid & i_ex_md_en & !i_ex_flush: latch operands/op, clear counter, o_ex_stall=1 combinationally same cycle, -> BUSY.
REQ-009 BUSY: one iteration per cycle (radix-2 shift-add multiply, restoring divide) on operand magnitudes; stall=1; after XLEN iterations -> DONE.
REQ-010 DONE: stall=0, sign-corrected result registered into o_ex_mem_res with valid=1 at that edge, -> IDLE; total stall XLEN+1 cycles.
REQ-011 While stall=1, EX/MEM SHALL load a bubble: valid, rf_wen, dmem_wen = 0.
REQ-012 MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits of 2*XLEN product with signed/signed, signed/unsigned, unsigned/unsigned operands.
REQ-013 Divide by zero: quotient all-ones, remainder = dividend, full latency.
REQ-014 Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder 0.
REQ-015 i_ex_flush in any state: -> IDLE, stall=0 same cycle, EX/MEM bubble, in-flight result discarded.
REQ-016 i_ex_valid=0 or flush SHALL force EX/MEM bubble regardless of i_ex_rf_wen/i_ex_dmem_wen.

Reset
REQ-017 i_ex_rst=1 at edge: FSM IDLE, counter 0, o_ex_mem_valid/rf_wen/dmem_wen=0, o_ex_stall=0 next cycle; reset mid-BUSY aborts operation.
REQ-018 Datapath registers (res, pc_plus_4, imm, wdata, waddr, side, operand latches) SHALL NOT be reset.

Structure
REQ-019 rv_pkg SHALL hold md_op_e, md_state_e and MD_ITER constant; XLEN, N_FWD remain module parameters.
REQ-020 Iterative engine SHALL be sub-module rv_muldiv_iter (start/op/a/b in; busy/done/result out); ALU reuses rv_alu.

Verification
REQ-021 ADD forwarded from source 2, XLEN=32: rs1=5 fwd2=7 sel[2]=2 -> o_ex_mem_res=12 one cycle later, stall never 1.
REQ-022 MULH -2 x 3 -> stall exactly 33 cycles, res=0xFFFFFFFF, valid=1 once.
REQ-023 DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
REQ-024 Flush at BUSY cycle 10 of DIVU -> stall=0 same cycle, no valid result emitted, next ADD completes normally.
REQ-025 Reset at BUSY cycle 5 -> IDLE, valid=0, stall=0; XLEN=64, N_FWD=3 build repeats REQ-022 with 65 stall cycles.
